// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DIV_ITER = XLEN;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIXUP,
      DONE
   } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] q_o,
   output logic [XLEN-1:0] r_o,
   output logic            last_o
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   logic [XLEN-1:0]  a_q;
   logic [XLEN-1:0]  b_q;
   logic [XLEN-1:0]  q_q;
   logic [XLEN-1:0]  r_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN:0]    r_shift;
   logic [XLEN:0]    r_sub;
   logic             q_bit;

   // a is shifted left each step, so a_q[XLEN-1] is the dividend bit a[XLEN-1-cnt]
   always_comb begin
      r_shift = {r_q, a_q[XLEN-1]};
      r_sub   = r_shift - {1'b0, b_q};
      q_bit   = (r_shift >= {1'b0, b_q});
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q   <= '0;
         b_q   <= '0;
         q_q   <= '0;
         r_q   <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         q_q   <= '0;
         r_q   <= '0;
         cnt_q <= '0;
      end else if (step_i) begin
         a_q   <= {a_q[XLEN-2:0], 1'b0};
         q_q   <= {q_q[XLEN-2:0], q_bit};
         r_q   <= q_bit ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign q_o    = q_q;
   assign r_o    = r_q;
   assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/div_ctrl.sv
// RV32M divide front-end: handshake, special-case resolution, sign handling and result hold.
module div_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [XLEN-1:0]  req_dividend_i,
   input  logic [XLEN-1:0]  req_divisor_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [XLEN-1:0]  rsp_result_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             busy_o
);

   div_state_e       state_q;
   div_op_e          op_q;
   logic [XLEN-1:0]  dividend_q;
   logic [XLEN-1:0]  divisor_q;
   logic [TAG_W-1:0] tag_q;
   logic             neg_quo_q;
   logic             neg_rem_q;

   logic             accept;
   logic             div_zero;
   logic             ovf;
   logic [XLEN-1:0]  special_res;
   logic             sd;
   logic             sv;
   logic [XLEN-1:0]  abs_a;
   logic [XLEN-1:0]  abs_b;
   logic [XLEN-1:0]  iter_q;
   logic [XLEN-1:0]  iter_r;
   logic             iter_last;
   logic [XLEN-1:0]  fix_res;

   assign req_ready_o = (state_q == IDLE) && !flush_i;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      div_zero    = (req_divisor_i == '0);
      ovf         = !req_op_i[0] && (req_dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (req_divisor_i == '1);
      special_res = '0;
      if (div_zero)
         special_res = req_op_i[1] ? req_dividend_i : '1;
      else if (ovf)
         special_res = req_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Magnitudes use modular negation, so |0x80000000| stays 0x80000000 as an unsigned value
   always_comb begin
      sd    = (op_q inside {DIV, REM}) && dividend_q[XLEN-1];
      sv    = (op_q inside {DIV, REM}) && divisor_q[XLEN-1];
      abs_a = sd ? -dividend_q : dividend_q;
      abs_b = sv ? -divisor_q  : divisor_q;
   end

   always_comb begin
      if (op_q inside {REM, REMU})
         fix_res = neg_rem_q ? -iter_r : iter_r;
      else
         fix_res = neg_quo_q ? -iter_q : iter_q;
   end

   div_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (state_q == PREP),
      .step_i (state_q == CALC),
      .a_i    (abs_a),
      .b_i    (abs_b),
      .q_o    (iter_q),
      .r_o    (iter_r),
      .last_o (iter_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         op_q         <= DIV;
         dividend_q   <= '0;
         divisor_q    <= '0;
         tag_q        <= '0;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_result_o <= '0;
         rsp_tag_o    <= '0;
      end else if (flush_i) begin
         state_q     <= IDLE;
         rsp_valid_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q       <= div_op_e'(req_op_i);
                  dividend_q <= req_dividend_i;
                  divisor_q  <= req_divisor_i;
                  tag_q      <= req_tag_i;
                  if (div_zero || ovf) begin
                     rsp_result_o <= special_res;
                     rsp_tag_o    <= req_tag_i;
                     rsp_valid_o  <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     state_q <= PREP;
                  end
               end
            end
            PREP: begin
               neg_quo_q <= sd ^ sv;
               neg_rem_q <= sd;
               state_q   <= CALC;
            end
            CALC: begin
               if (iter_last)
                  state_q <= FIXUP;
            end
            FIXUP: begin
               rsp_result_o <= fix_res;
               rsp_tag_o    <= tag_q;
               rsp_valid_o  <= 1'b1;
               state_q      <= DONE;
            end
            DONE: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with an expected-result queue checked at each response.
module tb_div_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_op_i;
   logic [31:0] req_dividend_i;
   logic [31:0] req_divisor_i;
   logic [4:0]  req_tag_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic [4:0]  rsp_tag_o;
   logic        busy_o;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  tag;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_i = ~clk_i;

   div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_op_i       (req_op_i),
      .req_dividend_i (req_dividend_i),
      .req_divisor_i  (req_divisor_i),
      .req_tag_i      (req_tag_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_result_o   (rsp_result_o),
      .rsp_tag_o      (rsp_tag_o),
      .busy_o         (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the language's truncating division operators
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return 32'($signed(a) / $signed(b));
         2'b01:   return a / b;
         2'b10:   return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat,
                       input bit push);
      exp_t e;
      @(negedge clk_i);
      check("req_ready_idle", 32'(req_ready_o), 32'd1);
      req_valid_i    = 1'b1;
      req_op_i       = op;
      req_dividend_i = a;
      req_divisor_i  = b;
      req_tag_i      = tag;
      @(posedge clk_i);
      #1;
      req_valid_i    = 1'b0;
      req_op_i       = ~op;
      req_dividend_i = ~a;
      req_divisor_i  = a ^ b ^ 32'h5A5A_0001;
      req_tag_i      = ~tag;
      if (push) begin
         e.result = exp;
         e.tag    = tag;
         e.lat    = lat;
         exp_q.push_back(e);
      end
   endtask

   task automatic collect(input int hold);
      exp_t        e;
      int          lat;
      logic [31:0] res;
      logic [4:0]  tg;
      lat = 1;
      while (!rsp_valid_o && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      check("rsp_valid_seen", 32'(rsp_valid_o), 32'd1);
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("result", rsp_result_o, e.result);
      check("tag", 32'(rsp_tag_o), 32'(e.tag));
      res = rsp_result_o;
      tg  = rsp_tag_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i);
         #1;
         check("hold_valid", 32'(rsp_valid_o), 32'd1);
         check("hold_result", rsp_result_o, res);
         check("hold_tag", 32'(rsp_tag_o), 32'(tg));
         check("hold_req_ready", 32'(req_ready_o), 32'd0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      check("post_hs_req_ready", 32'(req_ready_o), 32'd1);
      check("post_hs_valid", 32'(rsp_valid_o), 32'd0);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp, input int lat);
      send(op, a, b, tag, exp, lat, 1'b1);
      collect(0);
   endtask

   initial begin
      int          seen;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_i          = 1'b1;
      flush_i        = 1'b0;
      req_valid_i    = 1'b0;
      req_op_i       = 2'b00;
      req_dividend_i = '0;
      req_divisor_i  = '0;
      req_tag_i      = '0;
      rsp_ready_i    = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_result", rsp_result_o, 32'd0);
      check("rst_tag", 32'(rsp_tag_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);

      run(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 35);
      run(2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 35);
      run(2'b00, -32'sd7, 32'd2, 5'd5, 32'hFFFF_FFFD, 35);
      run(2'b10, -32'sd7, 32'd2, 5'd6, 32'hFFFF_FFFF, 35);
      run(2'b10, 32'd7, -32'sd2, 5'd7, 32'd1, 35);
      run(2'b00, 32'h8000_0000, 32'd2, 5'd8, 32'hC000_0000, 35);

      run(2'b00, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
      run(2'b11, 32'd5, 32'd0, 5'd10, 32'd5, 1);
      run(2'b00, 32'd0, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);

      run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);
      run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 35);

      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         run(rop, ra, rb, 5'(i + 16), model(rop, ra, rb),
             (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == '1)) ? 1 : 35);
      end

      // Backpressure: result held for 10 cycles with consumer stalled
      send(2'b00, 32'd1000, -32'sd3, 5'd21, 32'hFFFF_FEB3, 35, 1'b1);
      collect(10);

      // Flush in the 10th CALC cycle; nothing may come out afterwards
      send(2'b01, 32'd1234, 32'd5, 5'd22, 32'd0, 0, 1'b0);
      repeat (10) @(posedge clk_i);
      #1;
      check("calc_busy", 32'(busy_o), 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush_req_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      check("flush_busy", 32'(busy_o), 32'd0);
      check("flush_valid", 32'(rsp_valid_o), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (rsp_valid_o) seen++;
      end
      check("flush_no_rsp", 32'(seen), 32'd0);
      run(2'b01, 32'd9, 32'd3, 5'd23, 32'd3, 35);

      // Reset in the middle of CALC
      send(2'b01, 32'd77, 32'd4, 5'd24, 32'd0, 0, 1'b0);
      repeat (15) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("midrst_valid", 32'(rsp_valid_o), 32'd0);
      check("midrst_result", rsp_result_o, 32'd0);
      check("midrst_tag", 32'(rsp_tag_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_req_ready", 32'(req_ready_o), 32'd1);
      run(2'b11, 32'd77, 32'd4, 5'd25, 32'd1, 35);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
